alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/seq_muldiv.sv | 112 +++++++++++
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and iteration-mode types for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_LSR = 4'd5,
    OP_LSL = 4'd6,
    OP_MOD = 4'd7,
    OP_MUL = 4'd8,
    OP_DIV = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL = 2'd0,
    MD_DIV = 2'd1,
    MD_MOD = 2'd2
  } md_mode_e;

  localparam logic [3:0] OP_LAST = 4'd9;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  function automatic logic [1:0] md_mode_of(input logic [3:0] op);
    if (op == OP_MUL) return MD_MUL;
    else if (op == OP_DIV) return MD_DIV;
    else return MD_MOD;
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative shift-add multiply / restoring divide, one step per cycle over N cycles.
// The first step runs on the start edge; done pulses for one cycle after the Nth step.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result,
  output logic         hi_nonzero
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [1:0]    mode_q, mode_d, mode_s;
  logic [N-1:0]  opnd_q, opnd_d, opnd_s;
  logic [N-1:0]  hi_q, hi_d, hi_s;
  logic [N-1:0]  lo_q, lo_d, lo_s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [N:0]    mul_sum, div_shift;
  logic [N-1:0]  div_trial, hi_step, lo_step;
  logic          div_ge;

  // {hi, lo} is the product for MUL and {remainder, quotient} for DIV/MOD.
  always_comb begin
    mode_s = start ? mode : mode_q;
    if (start) begin
      opnd_s = (mode == MD_MUL) ? a : b;
      hi_s   = '0;
      lo_s   = (mode == MD_MUL) ? b : a;
    end else begin
      opnd_s = opnd_q;
      hi_s   = hi_q;
      lo_s   = lo_q;
    end

    mul_sum   = {1'b0, hi_s} + (lo_s[0] ? {1'b0, opnd_s} : '0);
    div_shift = {hi_s, lo_s[N-1]};
    div_ge    = (div_shift >= {1'b0, opnd_s});
    div_trial = div_shift[N-1:0] - opnd_s;

    if (mode_s == MD_MUL) begin
      hi_step = mul_sum[N:1];
      lo_step = {mul_sum[0], lo_s[N-1:1]};
    end else begin
      hi_step = div_ge ? div_trial : div_shift[N-1:0];
      lo_step = {lo_s[N-2:0], div_ge};
    end
  end

  always_comb begin
    mode_d = mode_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      mode_d = mode;
      opnd_d = opnd_s;
      hi_d   = hi_step;
      lo_d   = lo_step;
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done       = done_q;
  assign result     = (mode_q == MD_MOD) ? hi_q : lo_q;
  assign hi_nonzero = |hi_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops in 1 cycle, MUL/DIV/MOD in N+1 cycles, one op in flight.
// Result is held in DONE until out_ready; in_ready only in IDLE, so in_valid elsewhere is ignored.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic [3:0]   flags,
  output logic         err,
  output logic         dz
);

  state_e       state_q;
  logic [N-1:0] y_q;
  logic [3:0]   flags_q;
  logic         err_q, dz_q, mul_q, bz_q;

  logic [N:0]   add_ext, sub_ext, shr_ext, shl_ext;
  logic [N-1:0] sc_y;
  logic         sc_c, sc_v;

  logic         md_start, md_done, md_hi_nz;
  logic [N-1:0] md_result;

  // Shifts carry one guard bit so the last bit shifted out falls into the extension.
  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b};
    sub_ext = {1'b0, a} - {1'b0, b};
    shr_ext = {a, 1'b0} >> b;
    shl_ext = {1'b0, a} << b;
    sc_y = '0;
    sc_c = 1'b0;
    sc_v = 1'b0;
    case (op)
      OP_ADD: begin
        sc_y = add_ext[N-1:0];
        sc_c = add_ext[N];
        sc_v = (a[N-1] == b[N-1]) && (add_ext[N-1] != a[N-1]);
      end
      OP_SUB: begin
        sc_y = sub_ext[N-1:0];
        sc_c = ~sub_ext[N];
        sc_v = (a[N-1] != b[N-1]) && (sub_ext[N-1] != a[N-1]);
      end
      OP_AND: sc_y = a & b;
      OP_OR:  sc_y = a | b;
      OP_XOR: sc_y = a ^ b;
      OP_LSR: begin
        sc_y = shr_ext[N:1];
        sc_c = shr_ext[0];
      end
      OP_LSL: begin
        sc_y = shl_ext[N-1:0];
        sc_c = shl_ext[N];
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign md_start  = in_valid && in_ready && is_iter_op(op);

  seq_muldiv #(.N(N)) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (md_start),
    .mode       (md_mode_of(op)),
    .a          (a),
    .b          (b),
    .done       (md_done),
    .result     (md_result),
    .hi_nonzero (md_hi_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
      mul_q   <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mul_q <= (op == OP_MUL);
            bz_q  <= (b == '0);
            if (is_iter_op(op)) begin
              state_q <= S_BUSY;
            end else begin
              // Illegal opcodes leave sc_y/sc_c/sc_v at zero, giving flags 4'b0100.
              state_q <= S_DONE;
              y_q     <= sc_y;
              flags_q <= {sc_y[N-1], (sc_y == '0), sc_c, sc_v};
              err_q   <= (op > OP_LAST);
              dz_q    <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (md_done) begin
            state_q <= S_DONE;
            y_q     <= md_result;
            flags_q <= {md_result[N-1], (md_result == '0), 1'b0, mul_q & md_hi_nz};
            err_q   <= 1'b0;
            dz_q    <= ~mul_q & bz_q;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign y     = y_q;
  assign flags = flags_q;
  assign err   = err_q;
  assign dz    = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at N=4: vector table plus backpressure and reset sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, err, dz;
  logic [N-1:0] a, b, y;
  logic [3:0]   op, flags;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .err       (err),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a, b, y;
    logic [3:0]   flags;
    logic         err, dz;
    int           lat;
  } vec_t;

  typedef struct {
    logic [N-1:0] y;
    logic [3:0]   flags;
    logic         err, dz;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[25];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [N-1:0] va, input logic [N-1:0] vb,
                              input logic [N-1:0] ey, input logic [3:0] ef, input logic ee,
                              input logic ed, input int el);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.y = ey; v.flags = ef; v.err = ee; v.dz = ed; v.lat = el;
    return v;
  endfunction

  // Scoreboard side: every output transfer must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got y=%0h with no operation pending, expected none", y);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_y", y, e.y);
        check("out_flags", flags, e.flags);
        check("out_err", err, e.err);
        check("out_dz", dz, e.dz);
      end
    end
  end

  task automatic run_op(input int idx, input vec_t v);
    exp_t e;
    int   lat;
    @(negedge clk);
    a = v.a; b = v.b; op = v.op; in_valid = 1'b1;
    check($sformatf("v%0d_in_ready", idx), in_ready, 1);
    @(posedge clk);
    #1;
    e.y = v.y; e.flags = v.flags; e.err = v.err; e.dz = v.dz;
    sb_q.push_back(e);
    in_valid = 1'b0;
    a = 4'($urandom); b = 4'($urandom); op = 4'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, v.lat);
    if (out_valid === 1'b1) begin
      @(posedge clk);
      #1;
    end
    check($sformatf("v%0d_in_ready_after", idx), in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;

    //                op      a      b      y      flags    err   dz    lat
    vecs[0]  = mk(OP_ADD, 4'h9, 4'h8, 4'h1, 4'b0011, 1'b0, 1'b0, 1);
    vecs[1]  = mk(OP_ADD, 4'h3, 4'h4, 4'h7, 4'b0000, 1'b0, 1'b0, 1);
    vecs[2]  = mk(OP_ADD, 4'h8, 4'h8, 4'h0, 4'b0111, 1'b0, 1'b0, 1);
    vecs[3]  = mk(OP_SUB, 4'h2, 4'h5, 4'hD, 4'b1000, 1'b0, 1'b0, 1);
    vecs[4]  = mk(OP_SUB, 4'h7, 4'h7, 4'h0, 4'b0110, 1'b0, 1'b0, 1);
    vecs[5]  = mk(OP_SUB, 4'h8, 4'h1, 4'h7, 4'b0011, 1'b0, 1'b0, 1);
    vecs[6]  = mk(OP_AND, 4'hC, 4'hA, 4'h8, 4'b1000, 1'b0, 1'b0, 1);
    vecs[7]  = mk(OP_OR,  4'h5, 4'hA, 4'hF, 4'b1000, 1'b0, 1'b0, 1);
    vecs[8]  = mk(OP_XOR, 4'h6, 4'h6, 4'h0, 4'b0100, 1'b0, 1'b0, 1);
    vecs[9]  = mk(OP_LSR, 4'hB, 4'h1, 4'h5, 4'b0010, 1'b0, 1'b0, 1);
    vecs[10] = mk(OP_LSR, 4'hB, 4'h0, 4'hB, 4'b1000, 1'b0, 1'b0, 1);
    vecs[11] = mk(OP_LSR, 4'h6, 4'h6, 4'h0, 4'b0100, 1'b0, 1'b0, 1);
    vecs[12] = mk(OP_LSL, 4'hB, 4'h2, 4'hC, 4'b1000, 1'b0, 1'b0, 1);
    vecs[13] = mk(OP_LSL, 4'h9, 4'h1, 4'h2, 4'b0010, 1'b0, 1'b0, 1);
    vecs[14] = mk(OP_MUL, 4'h5, 4'h3, 4'hF, 4'b1000, 1'b0, 1'b0, 5);
    vecs[15] = mk(OP_MUL, 4'h6, 4'h6, 4'h4, 4'b0001, 1'b0, 1'b0, 5);
    vecs[16] = mk(OP_MUL, 4'h0, 4'h9, 4'h0, 4'b0100, 1'b0, 1'b0, 5);
    vecs[17] = mk(OP_MUL, 4'hF, 4'hF, 4'h1, 4'b0001, 1'b0, 1'b0, 5);
    vecs[18] = mk(OP_DIV, 4'hD, 4'h4, 4'h3, 4'b0000, 1'b0, 1'b0, 5);
    vecs[19] = mk(OP_MOD, 4'hD, 4'h4, 4'h1, 4'b0000, 1'b0, 1'b0, 5);
    vecs[20] = mk(OP_DIV, 4'h7, 4'h0, 4'hF, 4'b1000, 1'b0, 1'b1, 5);
    vecs[21] = mk(OP_MOD, 4'h7, 4'h0, 4'h7, 4'b0000, 1'b0, 1'b1, 5);
    vecs[22] = mk(OP_MOD, 4'hE, 4'hF, 4'hE, 4'b1000, 1'b0, 1'b0, 5);
    vecs[23] = mk(4'hC,   4'h3, 4'h3, 4'h0, 4'b0100, 1'b1, 1'b0, 1);
    vecs[24] = mk(4'hF,   4'h0, 4'h0, 4'h0, 4'b0100, 1'b1, 1'b0, 1);

    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", flags, 0);
    check("rst_err", err, 0);
    check("rst_dz", dz, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 25; i++) run_op(i, vecs[i]);

    // Backpressure: result held for three cycles while a second request is offered and ignored.
    @(negedge clk);
    out_ready = 1'b0; a = 4'h2; b = 4'h5; op = OP_SUB; in_valid = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{y: 4'hD, flags: 4'b1000, err: 1'b0, dz: 1'b0});
    a = 4'h1; b = 4'h1; op = OP_ADD;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_out_valid_%0d", k), out_valid, 1);
      check($sformatf("bp_y_stable_%0d", k), y, 4'hD);
      check($sformatf("bp_flags_stable_%0d", k), flags, 4'b1000);
      check($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    check("bp_ignored_not_run", seen, 0);

    // Reset two cycles into a MUL: outputs clear at once, aborted op never reports.
    @(negedge clk);
    a = 4'h5; b = 4'h3; op = OP_MUL; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 check("busy_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_y", y, 0);
    check("abort_flags", flags, 0);
    check("abort_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("abort_post_in_ready", in_ready, 1);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1) seen++;
    end
    check("abort_no_stale", seen, 0);
    run_op(100, vecs[1]);
    run_op(101, vecs[15]);

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
